mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the processor's single-port bus (we, addr, toMem out; fromMem in).
- Contains a word-addressed RAM, a loader port that fills the RAM before the core runs, and two memory-mapped registers: a console TX byte FIFO and a halt flag.
- Sits between the core and the testbench/top level. Its `run` output releases the core from reset once loading completes.

Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words; must be a power of two. AW = clog2(DEPTH_WORDS).
- MMIO_BASE, 32'hFFFF_0000: base byte address of the register window.
- FIFO_DEPTH, 4: console FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- we  in  1  bus write enable from core
- addr  in  32  bus byte address from core
- wdata  in  32  bus write data (core toMem)
- rdata  out  32  bus read data (core fromMem)
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader may transfer
- ld_data  in  32  loader word
- ld_last  in  1  marks final loader word
- run  out  1  high once loading is finished; core held in reset while low
- cons_valid  out  1  console byte available
- cons_ready  in  1  console sink accepts byte
- cons_data  out  8  console byte (FIFO head)
- halted  out  1  sticky halt flag
- bus_err  out  1  sticky error flag

Behaviour:
- States: LOAD (entered on reset) and RUN. RUN is left only by rst.
- Reset values:
  - state=LOAD, load pointer=0, run=0, ld_ready=1.
  - FIFO empty, cons_valid=0, cons_data=0.
  - halted=0, bus_err=0, overflow=0.
  - RAM contents are not cleared.
- Reset asserted mid-load or mid-run: everything above returns immediately to its reset value; partially loaded RAM words are retained.
- LOAD state:
  - ld_ready = 1 while pointer < DEPTH_WORDS.
  - Transfer when ld_valid & ld_ready: mem[ptr] <= ld_data, ptr <= ptr+1.
  - A transfer with ld_last=1 moves the block to RUN on the next edge; run=1 from that edge.
  - If ptr reaches DEPTH_WORDS without ld_last: ld_ready=0, bus_err=1, move to RUN.
  - Bus accesses are ignored in LOAD; rdata=0.
- RUN state: ld_ready=0; loader inputs are ignored.
- Address decode, RUN only:
  - RAM hit: addr[1:0]==0 and addr < 4*DEPTH_WORDS. Index is addr[AW+1:2].
  - REG hit: addr == MMIO_BASE (CONS) or addr == MMIO_BASE+4 (HALT).
  - Anything else is a miss.
- Reads are combinational (zero latency): rdata follows addr in the same cycle.
  - The core samples fromMem one edge after it drives addr, so a registered read is forbidden.
  - RAM hit: rdata = mem[index].
  - CONS: rdata = {29'b0, overflow, full, empty}.
  - HALT: rdata = {31'b0, halted}.
  - Miss: rdata = 32'hDEAD_BEEF. Never 32'hFFFF_FFFF, which the core treats as its stop word.
- Writes are synchronous: every rising edge with we=1 in RUN is one write. The master pulses we for one cycle per write.
  - RAM hit: mem[index] <= wdata.
  - CONS: push wdata[7:0]. If the FIFO is full and no pop occurs that edge, the byte is dropped and overflow is set (sticky).
  - HALT: halted <= 1 (sticky), regardless of data.
  - Miss (including misaligned): no state change except bus_err <= 1 (sticky).
  - Read misses do not set bus_err.
- Console FIFO:
  - cons_valid = !empty; cons_data = head entry.
  - Pop on cons_valid & cons_ready.
  - Push and pop on the same edge are both performed. When full, that push is accepted; when empty, the pop is impossible because cons_valid=0.
  - No fall-through: a byte pushed at edge N gives cons_valid=1 after edge N.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
  - Byte order out equals byte order in.
- Read-during-write to the same RAM word: rdata shows the old value until the edge, then the new value.

Test Plan:
- Load: reset, stream words 0xE3A0_1005, 0xE1A0_2001, then 0xFFFF_FFFF with ld_last -> ld_ready high throughout, run=1 one edge after the last word, addr 0/4/8 read those three words.
- Overflow load: DEPTH_WORDS=4, send 5 words with ld_last never set -> after 4 transfers ld_ready=0, bus_err=1, run=1, mem[0..3] hold the first 4 words.
- Console: write 0x41, 0x42, 0x43 to MMIO_BASE with cons_ready=0 -> CONS read = 0x0. Write 0x44 -> full, read = 0x2. Write 0x45 -> read = 0x6, the 0x45 byte is dropped. Set cons_ready=1 -> bytes 41,42,43,44 emerge on consecutive cycles, then read = 0x5.
- Simultaneous push/pop when full: fill 4 bytes, then write 0x55 on the same edge as a pop -> no overflow, output order 42,43,44,55 after the first pop of 41.
- Errors/halt: write to 0x0000_0002 and 0x1000_0000 -> RAM unchanged, bus_err=1, rdata=0xDEAD_BEEF. Write to MMIO_BASE+4 -> halted=1, read = 0x1.
- Reset mid-run: assert rst while the FIFO holds 2 bytes and halted=1 -> FIFO empty, halted=0, bus_err=0, run=0, ld_ready=1 immediately. RAM word 0 is still readable after a single-word reload at index 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the core's single-port bus: a loader-filled word RAM,
// a console TX byte FIFO and a halt flag. run releases the core once loading ends.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        run,
  output logic        cons_valid,
  input  logic        cons_ready,
  output logic [7:0]  cons_data,
  output logic        halted,
  output logic        bus_err,
  output logic        dbg_state
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] HALT_ADDR = MMIO_BASE + 32'd4;

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;

  state_t      r_state;
  logic [AW:0] r_ptr;
  logic        r_halted;
  logic        r_bus_err;
  logic        r_overflow;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [7:0]  r_fifo [FIFO_DEPTH];
  logic [FW:0] r_wp;
  logic [FW:0] r_rp;

  logic          w_run;
  logic          w_ld_xfer;
  logic          w_ptr_last;
  logic          w_ram_hit;
  logic          w_cons_hit;
  logic          w_halt_hit;
  logic          w_miss;
  logic          w_bus_wr;
  logic [AW-1:0] w_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_push_ok;

  // Loader handshake: a word moves on any edge where ld_valid and ld_ready are both high.
  assign w_run      = (r_state == S_RUN);
  assign ld_ready   = !w_run && !r_ptr[AW];
  assign w_ld_xfer  = ld_valid && ld_ready;
  assign w_ptr_last = (r_ptr[AW-1:0] == {AW{1'b1}});

  assign w_ram_hit  = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);
  assign w_cons_hit = (addr == MMIO_BASE);
  assign w_halt_hit = (addr == HALT_ADDR);
  assign w_miss     = !w_ram_hit && !w_cons_hit && !w_halt_hit;
  assign w_idx      = addr[AW+1:2];
  assign w_bus_wr   = w_run && we;

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[FW] != r_rp[FW]) && (r_wp[FW-1:0] == r_rp[FW-1:0]);
  assign w_pop     = !w_empty && cons_ready;
  assign w_push    = w_bus_wr && w_cons_hit;
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign run        = w_run;
  assign dbg_state  = r_state;
  assign halted     = r_halted;
  assign bus_err    = r_bus_err;
  assign cons_valid = !w_empty;
  assign cons_data  = w_empty ? 8'h00 : r_fifo[r_rp[FW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_LOAD;
      r_ptr     <= '0;
      r_halted  <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_ld_xfer) begin
            r_ptr <= r_ptr + (AW+1)'(1);
            if (ld_last) begin
              r_state <= S_RUN;
            end else if (w_ptr_last) begin
              // Image larger than the RAM: flag it and let the core run anyway.
              r_bus_err <= 1'b1;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (we) begin
            if (w_halt_hit) r_halted <= 1'b1;
            if (w_miss) r_bus_err <= 1'b1;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // RAM has no reset so a partial image survives a mid-load or mid-run reset.
  always_ff @(posedge clk) begin
    if (w_ld_xfer) begin
      r_mem[r_ptr[AW-1:0]] <= ld_data;
    end else if (w_bus_wr && w_ram_hit) begin
      r_mem[w_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wp[FW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + (FW+1)'(1);
      if (w_pop) r_rp <= r_rp + (FW+1)'(1);
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // Zero-latency read: the core samples fromMem one edge after driving addr.
  always_comb begin
    rdata = 32'h0;
    if (w_run) begin
      if (w_ram_hit) begin
        rdata = r_mem[w_idx];
      end else if (w_cons_hit) begin
        rdata = {29'b0, r_overflow, w_full, w_empty};
      end else if (w_halt_hit) begin
        rdata = {31'b0, r_halted};
      end else begin
        rdata = 32'hDEAD_BEEF;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized sessions checked
// against a queue/array reference model of the responder's rules.
module tb_mem_responder;
  localparam int          DW   = 4;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        run;
  logic        cons_valid;
  logic        cons_ready;
  logic [7:0]  cons_data;
  logic        halted;
  logic        bus_err;
  logic        dbg_state;

  mem_responder #(.DEPTH_WORDS(DW), .MMIO_BASE(BASE), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .run(run), .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_data(cons_data),
    .halted(halted), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model state; exp_q is the expected console byte stream
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_mem [DW];
  logic [7:0]  exp_q[$];
  bit          m_run;
  int          m_ptr;
  bit          m_halted;
  bit          m_bus_err;
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (!m_run) return 32'h0;
    if (a[1:0] == 2'b00 && a < 4 * DW) return m_mem[a >> 2];
    if (a == BASE) return {29'b0, m_ovf, exp_q.size() == FD, exp_q.size() == 0};
    if (a == BASE + 32'd4) return {31'b0, m_halted};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_run = 0; m_ptr = 0; m_halted = 0; m_bus_err = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // Advances the model by one clock edge using the inputs present just before it.
  task automatic model_step();
    bit pop;
    if (!m_run) begin
      if (ld_valid && m_ptr < DW) begin
        m_mem[m_ptr] = ld_data;
        m_ptr++;
        if (ld_last) m_run = 1;
        else if (m_ptr == DW) begin m_run = 1; m_bus_err = 1; end
      end
    end else begin
      pop = (exp_q.size() != 0) && cons_ready;
      if (pop) void'(exp_q.pop_front());
      if (we) begin
        if (addr[1:0] == 2'b00 && addr < 4 * DW) m_mem[addr >> 2] = wdata;
        else if (addr == BASE) begin
          if (exp_q.size() < FD) exp_q.push_back(wdata[7:0]);
          else m_ovf = 1;
        end
        else if (addr == BASE + 32'd4) m_halted = 1;
        else m_bus_err = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".run"}, {31'b0, run}, {31'b0, m_run});
    check({tag, ".dbg_state"}, {31'b0, dbg_state}, {31'b0, m_run});
    check({tag, ".ld_ready"}, {31'b0, ld_ready}, {31'b0, !m_run && m_ptr < DW});
    check({tag, ".cons_valid"}, {31'b0, cons_valid}, {31'b0, exp_q.size() != 0});
    check({tag, ".cons_data"}, {24'b0, cons_data}, (exp_q.size() != 0) ? {24'b0, exp_q[0]} : 32'h0);
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
    check({tag, ".bus_err"}, {31'b0, bus_err}, {31'b0, m_bus_err});
    check({tag, ".rdata"}, rdata, exp_rdata(addr));
  endtask

  // Driver tasks: inputs change 1 time unit after a rising edge, outputs sampled 1 later.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_rst();
    #2;
    rst = 1; we = 0; ld_valid = 0; ld_last = 0;
    model_reset();
    #1;
    check_all("rst");
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic ld(input logic [31:0] d, input logic l);
    ld_valid = 1; ld_data = d; ld_last = l; we = 0;
    step("ld");
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1; addr = a; wdata = d;
    step("wr");
    we = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    we = 0; addr = a;
    #1;
    check(tag, rdata, e);
    step(tag);
  endtask

  logic [7:0]  cons_exp [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
  logic [7:0]  pp_exp   [4] = '{8'h42, 8'h43, 8'h44, 8'h55};
  logic [31:0] ovl_w    [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};

  initial begin
    rst = 1; we = 0; addr = 0; wdata = 0; ld_valid = 0; ld_data = 0; ld_last = 0; cons_ready = 0;
    model_reset();

    // Reset state and a three-word load
    assert_rst();
    check("rst.cons_data", {24'b0, cons_data}, 32'h0);
    check("rst.ld_ready", {31'b0, ld_ready}, 32'h1);
    release_rst();
    ld(32'hE3A0_1005, 1'b0);
    ld(32'hE1A0_2001, 1'b0);
    #1 check("load.run_low", {31'b0, run}, 32'h0);
    ld(32'hFFFF_FFFF, 1'b1);
    #1 check("load.run_high", {31'b0, run}, 32'h1);
    rd("load.rd0", 32'h0, 32'hE3A0_1005);
    rd("load.rd4", 32'h4, 32'hE1A0_2001);
    rd("load.rd8", 32'h8, 32'hFFFF_FFFF);

    // Oversized image: no ld_last within DEPTH words
    assert_rst();
    release_rst();
    for (int i = 0; i < 4; i++) ld(ovl_w[i], 1'b0);
    #1;
    check("ovl.ld_ready", {31'b0, ld_ready}, 32'h0);
    check("ovl.bus_err", {31'b0, bus_err}, 32'h1);
    check("ovl.run", {31'b0, run}, 32'h1);
    ld(ovl_w[4], 1'b0);
    for (int i = 0; i < 4; i++) rd("ovl.mem", 32'(i * 4), ovl_w[i]);

    // Console fill, overflow and drain
    cons_ready = 0;
    wr(BASE, 32'h41); wr(BASE, 32'h42); wr(BASE, 32'h43);
    rd("cons.stat3", BASE, 32'h0);
    wr(BASE, 32'h44);
    rd("cons.full", BASE, 32'h2);
    wr(BASE, 32'h45);
    rd("cons.ovf", BASE, 32'h6);
    cons_ready = 1; we = 0; addr = BASE;
    for (int i = 0; i < 4; i++) begin
      #1 check("cons.out", {24'b0, cons_data}, {24'b0, cons_exp[i]});
      step("cons.drain");
    end
    rd("cons.empty", BASE, 32'h5);
    cons_ready = 0;

    // Push and pop on the same edge while full
    assert_rst();
    release_rst();
    ld(32'hA5A5_0000, 1'b1);
    wr(BASE, 32'h41); wr(BASE, 32'h42); wr(BASE, 32'h43); wr(BASE, 32'h44);
    cons_ready = 1; we = 1; addr = BASE; wdata = 32'h55;
    #1 check("pp.head", {24'b0, cons_data}, 32'h41);
    step("pp.both");
    we = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check("pp.out", {24'b0, cons_data}, {24'b0, pp_exp[i]});
      step("pp.drain");
    end
    rd("pp.stat", BASE, 32'h1);
    cons_ready = 0;

    // Misses and halt
    rd("err.rdmiss", 32'h20, 32'hDEAD_BEEF);
    check("err.rdmiss_noerr", {31'b0, bus_err}, 32'h0);
    wr(32'h0000_0002, 32'h1234_5678);
    wr(32'h1000_0000, 32'h8765_4321);
    #1 check("err.flag", {31'b0, bus_err}, 32'h1);
    rd("err.mis", 32'h0000_0002, 32'hDEAD_BEEF);
    rd("err.far", 32'h1000_0000, 32'hDEAD_BEEF);
    rd("err.ram0", 32'h0, 32'hA5A5_0000);
    wr(BASE + 32'd4, 32'h0);
    #1 check("halt.flag", {31'b0, halted}, 32'h1);
    rd("halt.rd", BASE + 32'd4, 32'h1);

    // Reset mid-run with bytes queued
    wr(BASE, 32'h61); wr(BASE, 32'h62);
    assert_rst();
    check("mid.cons_valid", {31'b0, cons_valid}, 32'h0);
    check("mid.halted", {31'b0, halted}, 32'h0);
    check("mid.bus_err", {31'b0, bus_err}, 32'h0);
    check("mid.run", {31'b0, run}, 32'h0);
    check("mid.ld_ready", {31'b0, ld_ready}, 32'h1);
    release_rst();
    ld(32'hCAFE_0001, 1'b1);
    rd("mid.reload0", 32'h0, 32'hCAFE_0001);
    rd("mid.keep1", 32'h4, ovl_w[1]);

    // Randomized sessions
    for (int s = 0; s < 8; s++) begin
      assert_rst();
      release_rst();
      for (int c = 0; c < 12 && !m_run; c++) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = $urandom;
        ld_last  = ($urandom_range(0, 3) == 0);
        step("rnd.load");
      end
      ld_valid = 0; ld_last = 0;
      for (int c = 0; c < 80; c++) begin
        we         = 1'($urandom_range(0, 1));
        wdata      = $urandom;
        cons_ready = 1'($urandom_range(0, 1));
        ld_valid   = 1'($urandom_range(0, 1));
        ld_data    = $urandom;
        case ($urandom_range(0, 7))
          0, 1:    addr = 32'($urandom_range(0, DW - 1)) * 32'd4;
          2, 3, 4: addr = BASE;
          5:       addr = ($urandom_range(0, 9) == 0) ? BASE + 32'd4 : BASE + 32'd8;
          6:       addr = 32'($urandom_range(0, 4 * DW + 3));
          default: addr = $urandom;
        endcase
        step("rnd.run");
      end
      we = 0; ld_valid = 0; cons_ready = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
